// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//
// Memory-access pipeline stage. Takes the execute-stage bundle, performs loads
// and stores over a req/gnt/rvalid data-memory port, raises a one-cycle PC
// redirect for taken branches and jumps, and emits exactly one writeback beat
// for every accepted bundle.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   ex_valid/ex_ready   execute bundle handshake; ready only while idle
//   control_word_ex     {branch_taken, rf_wb, mem_we, wb_src[1:0], pc_src,
//                        funct3[2:0]}
//   calculated_adr      branch/jump target
//   pc_plus_4_ex        link value
//   ALU_result          ALU output, also the load/store byte address
//   regfileb_ex         store data
//   ex_rd               destination register
//   dmem_*              data-memory request port (word address + byte lanes)
//   redirect_valid/pc   one-cycle PC redirect
//   wb_*                one-cycle writeback beat
//
// Parameters
//   MAX_WAIT            cycles spent waiting for a response before the access
//                       is abandoned with a fault; 0 waits forever
// -----------------------------------------------------------------------------
module mem_access_stage #(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [8:0]  control_word_ex,
    input  logic [31:0] calculated_adr,
    input  logic [31:0] pc_plus_4_ex,
    input  logic [31:0] ALU_result,
    input  logic [31:0] regfileb_ex,
    input  logic [4:0]  ex_rd,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        wb_valid,
    output logic        wb_rf_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_fault
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    // Wide enough to hold MAX_WAIT; at least one bit so the register exists.
    localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    state_t        state;
    logic [CW-1:0] wait_cnt;

    // Captured bundle fields needed after the accept cycle.
    logic          op_rf_wb;
    logic [1:0]    op_wb_src;
    logic [2:0]    op_f3;
    logic [31:0]   op_alu;
    logic [31:0]   op_pc4;
    logic [4:0]    op_rd;

    // Control word fields.
    logic          ex_branch;
    logic          ex_rf_wb;
    logic          ex_mem_we;
    logic [1:0]    ex_wb_src;
    logic          ex_pc_src;
    logic [2:0]    ex_f3;

    assign {ex_branch, ex_rf_wb, ex_mem_we, ex_wb_src, ex_pc_src, ex_f3} = control_word_ex;

    logic accept;
    logic ex_is_mem;
    logic timeout;

    assign accept    = ex_valid && ex_ready;
    assign ex_is_mem = ex_mem_we | (ex_wb_src == 2'b01);
    assign timeout   = (MAX_WAIT != 0) && ((int'(wait_cnt) + 1) == MAX_WAIT);

    // -------------------------------------------------------------------------
    // Request decode: width legality, alignment, byte lanes and store data.
    // Loads drive no byte enables and no write data.
    // -------------------------------------------------------------------------
    logic        legal_width;
    logic        misaligned;
    logic        ex_bad;
    logic [3:0]  ex_be;
    logic [31:0] ex_wdata;

    always_comb begin
        // NOTE: every signal written here gets a value on every path first,
        // otherwise synthesis infers a latch to hold the old value.
        ex_be    = 4'h0;
        ex_wdata = 32'h0;

        legal_width = ex_mem_we ? (ex_f3 inside {3'b000, 3'b001, 3'b010})
                                : (ex_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        misaligned  = ((ex_f3[1:0] == 2'b01) && ALU_result[0]) ||
                      ((ex_f3[1:0] == 2'b10) && (ALU_result[1:0] != 2'b00));
        ex_bad      = !legal_width || misaligned;

        if (ex_mem_we) begin
            case (ex_f3[1:0])
                2'b00: begin
                    ex_be    = 4'b0001 << ALU_result[1:0];
                    ex_wdata = {4{regfileb_ex[7:0]}};
                end
                2'b01: begin
                    ex_be    = 4'b0011 << ALU_result[1:0];
                    ex_wdata = {2{regfileb_ex[15:0]}};
                end
                default: begin
                    ex_be    = 4'hF;
                    ex_wdata = regfileb_ex;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Load data: bring the addressed lane down to bit 0, then extend.
    // -------------------------------------------------------------------------
    logic [31:0] ld_shifted;
    logic [31:0] ld_data;

    always_comb begin
        ld_shifted = dmem_rdata >> {op_alu[1:0], 3'b000};
        case (op_f3)
            3'b000:  ld_data = {{24{ld_shifted[7]}},  ld_shifted[7:0]};
            3'b001:  ld_data = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            3'b100:  ld_data = {24'h0, ld_shifted[7:0]};
            3'b101:  ld_data = {16'h0, ld_shifted[15:0]};
            default: ld_data = ld_shifted;
        endcase
    end

    function automatic logic [31:0] wb_select(input logic [1:0]  src,
                                              input logic [31:0] alu,
                                              input logic [31:0] ld,
                                              input logic [31:0] pc4);
        case (src)
            2'b01:   return ld;
            2'b10:   return pc4;
            default: return alu;
        endcase
    endfunction

    // -------------------------------------------------------------------------
    // Control FSM with registered outputs.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            ex_ready       <= 1'b0;
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= 32'h0;
            dmem_be        <= 4'h0;
            dmem_wdata     <= 32'h0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'h0;
            wb_valid       <= 1'b0;
            wb_rf_we       <= 1'b0;
            wb_rd          <= 5'h0;
            wb_data        <= 32'h0;
            wb_fault       <= 1'b0;
            op_rf_wb       <= 1'b0;
            op_wb_src      <= 2'b00;
            op_f3          <= 3'b000;
            op_alu         <= 32'h0;
            op_pc4         <= 32'h0;
            op_rd          <= 5'h0;
        end else begin
            // Pulses default low; a beat lasts exactly one cycle.
            redirect_valid <= 1'b0;
            wb_valid       <= 1'b0;

            case (state)
                IDLE: begin
                    ex_ready <= 1'b1;
                    if (accept) begin
                        op_rf_wb  <= ex_rf_wb;
                        op_wb_src <= ex_wb_src;
                        op_f3     <= ex_f3;
                        op_alu    <= ALU_result;
                        op_pc4    <= pc_plus_4_ex;
                        op_rd     <= ex_rd;

                        // Redirect does not depend on whether the op touches memory.
                        redirect_valid <= ex_branch | ex_pc_src;
                        redirect_pc    <= calculated_adr & ~32'h1;

                        if (!ex_is_mem) begin
                            wb_valid <= 1'b1;
                            wb_fault <= 1'b0;
                            wb_rd    <= ex_rd;
                            wb_rf_we <= ex_rf_wb && (ex_rd != 5'd0);
                            wb_data  <= wb_select(ex_wb_src, ALU_result, 32'h0, pc_plus_4_ex);
                        end else if (ex_bad) begin
                            // Rejected access: fault beat, bus untouched.
                            wb_valid <= 1'b1;
                            wb_fault <= 1'b1;
                            wb_rd    <= ex_rd;
                            wb_rf_we <= 1'b0;
                            wb_data  <= 32'h0;
                        end else begin
                            state      <= REQ;
                            ex_ready   <= 1'b0;
                            dmem_req   <= 1'b1;
                            dmem_we    <= ex_mem_we;
                            dmem_addr  <= {ALU_result[31:2], 2'b00};
                            dmem_be    <= ex_be;
                            dmem_wdata <= ex_wdata;
                        end
                    end
                end

                REQ: begin
                    // Request fields stay frozen until granted; rvalid is ignored here.
                    if (dmem_gnt) begin
                        dmem_req <= 1'b0;
                        wait_cnt <= '0;
                        state    <= WAIT;
                    end
                end

                WAIT: begin
                    if (dmem_rvalid) begin
                        state    <= IDLE;
                        ex_ready <= 1'b1;
                        wb_valid <= 1'b1;
                        wb_fault <= 1'b0;
                        wb_rd    <= op_rd;
                        wb_rf_we <= op_rf_wb && (op_rd != 5'd0);
                        wb_data  <= wb_select(op_wb_src, op_alu, ld_data, op_pc4);
                    end else if (timeout) begin
                        state    <= IDLE;
                        ex_ready <= 1'b1;
                        wb_valid <= 1'b1;
                        wb_fault <= 1'b1;
                        wb_rd    <= op_rd;
                        wb_rf_we <= 1'b0;
                        wb_data  <= 32'h0;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end

                default: begin
                    state    <= IDLE;
                    ex_ready <= 1'b1;
                    dmem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [8:0]  control_word_ex;
    logic [31:0] calculated_adr;
    logic [31:0] pc_plus_4_ex;
    logic [31:0] ALU_result;
    logic [31:0] regfileb_ex;
    logic [4:0]  ex_rd;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        wb_valid;
    logic        wb_rf_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_fault;

    int total = 0;
    int bad   = 0;

    mem_access_stage #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ex_valid        (ex_valid),
        .ex_ready        (ex_ready),
        .control_word_ex (control_word_ex),
        .calculated_adr  (calculated_adr),
        .pc_plus_4_ex    (pc_plus_4_ex),
        .ALU_result      (ALU_result),
        .regfileb_ex     (regfileb_ex),
        .ex_rd           (ex_rd),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_be         (dmem_be),
        .dmem_wdata      (dmem_wdata),
        .dmem_gnt        (dmem_gnt),
        .dmem_rvalid     (dmem_rvalid),
        .dmem_rdata      (dmem_rdata),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .wb_valid        (wb_valid),
        .wb_rf_we        (wb_rf_we),
        .wb_rd           (wb_rd),
        .wb_data         (wb_data),
        .wb_fault        (wb_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_mem;
        bit          fault;
        bit          redir;
        bit          we;
        bit          rf_we;
        logic [31:0] rpc;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] data;
        logic [3:0]  be;
    } exp_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] mk(input bit br, input bit rf, input bit we,
                                      input logic [1:0] src, input bit pcs, input logic [2:0] f3);
        return {br, rf, we, src, pcs, f3};
    endfunction

    // Reference model: what the stage must produce for one bundle, derived
    // from access size, byte offset and plain arithmetic.
    function automatic exp_t model(input logic [8:0]  ctrl,
                                   input logic [31:0] alu,
                                   input logic [31:0] b,
                                   input logic [31:0] tgt,
                                   input logic [31:0] pc4,
                                   input logic [4:0]  rd,
                                   input logic [31:0] rdata);
        exp_t        e;
        int          f3;
        int          src;
        int          nbytes;
        int          off;
        bit          is_load;
        bit          legal;
        logic [63:0] v;
        f3       = int'(ctrl[2:0]);
        src      = int'(ctrl[5:4]);
        e.we     = ctrl[6];
        e.redir  = ctrl[8] | ctrl[3];
        e.rpc    = tgt - (tgt % 2);
        is_load  = !e.we && (src == 1);
        e.is_mem = e.we || is_load;
        nbytes   = 1 << (f3 % 4);
        off      = int'(alu % 4);
        legal    = is_load ? !(f3 == 3 || f3 >= 6) : (f3 <= 2);
        e.fault  = e.is_mem && (!legal || (alu % nbytes) != 0);
        e.addr   = alu - (alu % 4);
        e.be     = 4'h0;
        e.wdata  = 32'h0;
        if (e.we && legal) begin
            e.be = 4'(((1 << nbytes) - 1) << off);
            case (nbytes)
                1:       e.wdata = b[7:0] * 32'h0101_0101;
                2:       e.wdata = b[15:0] * 32'h0001_0001;
                default: e.wdata = b;
            endcase
        end
        v = 64'(rdata) >> (8 * off);
        if (nbytes < 4) begin
            v = v % (64'd1 << (8 * nbytes));
            if (f3 < 4 && v >= (64'd1 << (8 * nbytes - 1)))
                v = v - (64'd1 << (8 * nbytes));
        end
        if (e.fault)       e.data = 32'h0;
        else if (src == 2) e.data = pc4;
        else if (src == 1) e.data = v[31:0];
        else               e.data = alu;
        e.rf_we = ctrl[7] && !e.fault && (rd != 5'd0);
        return e;
    endfunction

    // Runs one bundle. gd = REQ cycles before gnt, rdly = WAIT cycles before
    // rvalid, no_resp = never respond (expect a timeout fault).
    task automatic run_op(input string tag, input logic [8:0] ctrl,
                          input logic [31:0] alu, input logic [31:0] b,
                          input logic [31:0] tgt, input logic [31:0] pc4,
                          input logic [4:0] rd, input logic [31:0] rdata,
                          input int gd, input int rdly, input bit no_resp);
        exp_t        e;
        bit          bus;
        bit          exp_req;
        bit          req_ok;
        bit          redir_ok;
        int          exp_wb_k;
        int          wb_k;
        int          wb_cnt;
        logic [31:0] g_data, g_rpc, g_addr, g_wdata;
        logic [4:0]  g_rd;
        logic [3:0]  g_be;
        logic        g_rf_we, g_fault, g_we;

        e   = model(ctrl, alu, b, tgt, pc4, rd, rdata);
        bus = e.is_mem && !e.fault;
        if (bus && no_resp) begin
            e.fault = 1'b1;
            e.data  = 32'h0;
            e.rf_we = 1'b0;
        end
        if (!bus)         exp_wb_k = 1;
        else if (no_resp) exp_wb_k = 2 + gd + MAX_WAIT;
        else              exp_wb_k = 3 + gd + rdly;

        @(negedge clk);
        check({tag, ".ready_in"}, 32'(ex_ready), 32'd1);
        control_word_ex = ctrl;
        ALU_result      = alu;
        regfileb_ex     = b;
        calculated_adr  = tgt;
        pc_plus_4_ex    = pc4;
        ex_rd           = rd;
        ex_valid        = 1'b1;

        wb_k = -1; wb_cnt = 0; req_ok = 1'b1; redir_ok = 1'b1;
        g_data = 'x; g_rpc = 'x; g_addr = 'x; g_wdata = 'x;
        g_rd = 'x; g_be = 'x; g_rf_we = 'x; g_fault = 'x; g_we = 'x;

        for (int k = 1; k <= exp_wb_k + 3; k++) begin
            @(negedge clk);
            ex_valid    = 1'b0;
            dmem_gnt    = 1'b0;
            dmem_rvalid = 1'b0;
            // Sample what the previous edge produced.
            exp_req = bus && (k <= 1 + gd);
            if (dmem_req !== exp_req) req_ok = 1'b0;
            if (exp_req && k > 1 && (dmem_addr !== g_addr || dmem_be !== g_be ||
                                     dmem_wdata !== g_wdata || dmem_we !== g_we))
                req_ok = 1'b0;
            if (k == 1) begin
                g_addr = dmem_addr; g_be = dmem_be; g_wdata = dmem_wdata; g_we = dmem_we;
                g_rpc  = redirect_pc;
            end
            if (redirect_valid !== ((k == 1) && e.redir)) redir_ok = 1'b0;
            if (wb_valid === 1'b1) begin
                wb_cnt++;
                wb_k    = k;
                g_data  = wb_data;
                g_rd    = wb_rd;
                g_rf_we = wb_rf_we;
                g_fault = wb_fault;
            end
            // Drive the bus for cycle k.
            if (bus) begin
                if (k == 1 + gd) dmem_gnt = 1'b1;
                if (gd > 0 && k == 1) begin
                    dmem_rvalid = 1'b1;   // response while still in REQ: ignored
                    dmem_rdata  = $urandom;
                end
                if (!no_resp && k == 2 + gd + rdly) begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata  = rdata;
                end
            end
            if (k == exp_wb_k + 1) begin
                dmem_rvalid = 1'b1;       // stray response/grant after completion
                dmem_gnt    = 1'b1;
                dmem_rdata  = $urandom;
            end
        end
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;

        check({tag, ".wb_beats"}, 32'(wb_cnt), 32'd1);
        check({tag, ".wb_cycle"}, 32'(wb_k), 32'(exp_wb_k));
        check({tag, ".wb_data"}, g_data, e.data);
        check({tag, ".wb_rd"}, 32'(g_rd), 32'(rd));
        check({tag, ".wb_rf_we"}, 32'(g_rf_we), 32'(e.rf_we));
        check({tag, ".wb_fault"}, 32'(g_fault), 32'(e.fault));
        check({tag, ".redirect_pattern"}, 32'(redir_ok), 32'd1);
        if (e.redir) check({tag, ".redirect_pc"}, g_rpc, e.rpc);
        check({tag, ".req_pattern"}, 32'(req_ok), 32'd1);
        if (bus) begin
            check({tag, ".addr"}, g_addr, e.addr);
            check({tag, ".be"}, 32'(g_be), 32'(e.be));
            check({tag, ".we"}, 32'(g_we), 32'(e.we));
            check({tag, ".wdata"}, g_wdata, e.wdata);
        end
        check({tag, ".ready_out"}, 32'(ex_ready), 32'd1);
    endtask

    // Reset in the middle of a load: nothing may come out afterwards.
    task automatic reset_mid_op(input string tag, input bit in_wait);
        int beats;
        @(negedge clk);
        check({tag, ".ready_in"}, 32'(ex_ready), 32'd1);
        control_word_ex = mk(1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 3'b010);
        ALU_result      = 32'h0000_3000;
        ex_rd           = 5'd7;
        ex_valid        = 1'b1;
        @(negedge clk);
        ex_valid = 1'b0;
        check({tag, ".req_before"}, 32'(dmem_req), 32'd1);
        if (in_wait) begin
            dmem_gnt = 1'b1;
            @(negedge clk);
            dmem_gnt = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        check({tag, ".req_in_reset"}, 32'(dmem_req), 32'd0);
        check({tag, ".wb_in_reset"}, 32'(wb_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        beats = 0;
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin
                dmem_rvalid = 1'b1;
                dmem_rdata  = $urandom;
            end
            @(negedge clk);
            dmem_rvalid = 1'b0;
            if (wb_valid === 1'b1)       beats++;
            if (redirect_valid === 1'b1) beats++;
            if (dmem_req === 1'b1)       beats++;
        end
        check({tag, ".no_activity"}, 32'(beats), 32'd0);
        check({tag, ".ready_out"}, 32'(ex_ready), 32'd1);
    endtask

    initial begin
        logic [8:0]  c;
        logic [31:0] alu;
        int          kind;
        int          s;

        rst_n = 1'b0; ex_valid = 1'b0; control_word_ex = '0; calculated_adr = '0;
        pc_plus_4_ex = '0; ALU_result = '0; regfileb_ex = '0; ex_rd = '0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;

        #12;
        check("reset.req", 32'(dmem_req), 32'd0);
        check("reset.wb_valid", 32'(wb_valid), 32'd0);
        check("reset.redirect", 32'(redirect_valid), 32'd0);
        check("reset.ready", 32'(ex_ready), 32'd0);
        check("reset.wb_data", wb_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD
        run_op("add", mk(0, 1, 0, 2'b00, 0, 3'b000), 32'h1234, 32'h0, 32'h0, 32'h0, 5'd5,
               32'h0, 0, 0, 1'b0);
        // LB / LBU at byte 3
        run_op("lb", mk(0, 1, 0, 2'b01, 0, 3'b000), 32'h1003, 32'h0, 32'h0, 32'h0, 5'd6,
               32'h8012_3456, 0, 0, 1'b0);
        run_op("lbu", mk(0, 1, 0, 2'b01, 0, 3'b100), 32'h1003, 32'h0, 32'h0, 32'h0, 5'd6,
               32'h8012_3456, 0, 0, 1'b0);
        // SH aligned and misaligned
        run_op("sh", mk(0, 0, 1, 2'b00, 0, 3'b001), 32'h2002, 32'hABCD, 32'h0, 32'h0, 5'd0,
               32'h0, 1, 0, 1'b0);
        run_op("sh_mis", mk(0, 1, 1, 2'b00, 0, 3'b001), 32'h2001, 32'hABCD, 32'h0, 32'h0, 5'd3,
               32'h0, 0, 0, 1'b0);
        // JAL
        run_op("jal", mk(0, 1, 0, 2'b10, 1, 3'b000), 32'h0, 32'h0, 32'h405, 32'h104, 5'd1,
               32'h0, 0, 0, 1'b0);
        // LW that never gets a response
        run_op("lw_timeout", mk(0, 1, 0, 2'b01, 0, 3'b010), 32'h3000, 32'h0, 32'h0, 32'h0, 5'd9,
               32'h0, 0, 0, 1'b1);
        // Illegal load width
        run_op("ld_illegal", mk(1, 1, 0, 2'b01, 0, 3'b011), 32'h3000, 32'h0, 32'h77, 32'h0, 5'd9,
               32'h0, 0, 0, 1'b0);

        reset_mid_op("rst_wait", 1'b1);
        reset_mid_op("rst_req", 1'b0);

        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 2);
            s    = $urandom_range(0, 2);
            alu  = $urandom;
            if ($urandom_range(0, 1) == 1) alu[1:0] = 2'b00;
            case (kind)
                0: c = mk(1'($urandom), 1'($urandom), 1'b0, (s == 0) ? 2'b00 : 2'(s + 1),
                          1'($urandom), 3'($urandom));
                1: c = mk(1'($urandom), 1'($urandom), 1'b0, 2'b01,
                          1'($urandom), 3'($urandom));
                default: c = mk(1'($urandom), 1'($urandom), 1'b1, (s == 0) ? 2'b00 : 2'(s + 1),
                                1'($urandom), 3'($urandom_range(0, 3)));
            endcase
            run_op($sformatf("rnd%0d", i), c, alu, $urandom, $urandom, $urandom,
                   5'($urandom), $urandom, $urandom_range(0, 2), $urandom_range(0, 2),
                   ($urandom_range(0, 7) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
